// File: rtl/control_sumador_serie_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   - ANCHO_DEF    : default operand/sum width
//   - estado_t     : controller states (encoding 2'd3 is illegal and recovers to REPOSO)
//   - ancho_cuenta : width of the bit counter, max(1, clog2(n))
package control_sumador_serie_pkg;

    localparam int unsigned ANCHO_DEF = 8;

    typedef enum logic [1:0] {
        ST_REPOSO  = 2'd0,
        ST_SUMANDO = 2'd1,
        ST_HECHO   = 2'd2
    } estado_t;

    function automatic int unsigned ancho_cuenta(input int unsigned n);
        if (n > 1) begin
            return $clog2(n);
        end
        return 1;
    endfunction

endpackage

// File: rtl/control_sumador_serie_half_adder.sv
// Half adder cell; two of these plus an OR form the serial full-adder.
//   i_a, i_b   : input bits
//   o_suma     : i_a ^ i_b
//   o_acarreo  : i_a & i_b
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_suma,
    output logic o_acarreo
);

    always_comb begin
        o_suma    = i_a ^ i_b;
        o_acarreo = i_a & i_b;
    end

endmodule

// File: rtl/control_sumador_serie.sv
// Bit-serial adder controller. Accepts two ANCHO-bit operands over a
// valid/ready handshake, adds them LSB-first one bit per clock through a
// single full-adder cell, and presents sum and carry-out over a second
// valid/ready handshake.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_valido / o_listo           : operand handshake
//   i_operando_a, i_operando_b   : operands, sampled only on accept
//   o_valido / i_listo           : result handshake
//   o_suma, o_acarreo            : sum mod 2^ANCHO and carry-out (meaningful while o_valido=1)
module control_sumador_serie
    import control_sumador_serie_pkg::*;
#(
    parameter int unsigned ANCHO = ANCHO_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valido,
    output logic             o_listo,
    input  logic [ANCHO-1:0] i_operando_a,
    input  logic [ANCHO-1:0] i_operando_b,
    output logic             o_valido,
    input  logic             i_listo,
    output logic [ANCHO-1:0] o_suma,
    output logic             o_acarreo
);

    localparam int unsigned    CW     = ancho_cuenta(ANCHO);
    localparam logic [CW-1:0]  ULTIMO = CW'(ANCHO - 1);

    estado_t          estado_q, estado_d;
    logic             listo_q, listo_d;
    logic             valido_q, valido_d;
    logic [ANCHO-1:0] a_q, a_d;
    logic [ANCHO-1:0] b_q, b_d;
    logic [ANCHO-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Full-adder cell: first half adder combines the operand bits, second
    // adds the stored carry; either half adder may generate the carry.
    logic p0, g0, s_bit, g1, c_sig;

    half_adder u_ha0 (
        .i_a       (a_q[0]),
        .i_b       (b_q[0]),
        .o_suma    (p0),
        .o_acarreo (g0)
    );

    half_adder u_ha1 (
        .i_a       (p0),
        .i_b       (c_q),
        .o_suma    (s_bit),
        .o_acarreo (g1)
    );

    assign c_sig = g0 | g1;

    always_comb begin
        estado_d = estado_q;
        listo_d  = listo_q;
        valido_d = valido_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        c_d      = c_q;
        cnt_d    = cnt_q;

        case (estado_q)
            ST_REPOSO: begin
                listo_d  = 1'b1;
                valido_d = 1'b0;
                if (i_valido && listo_q) begin
                    a_d      = i_operando_a;
                    b_d      = i_operando_b;
                    sum_d    = '0;
                    c_d      = 1'b0;
                    cnt_d    = '0;
                    listo_d  = 1'b0;
                    estado_d = ST_SUMANDO;
                end
            end
            ST_SUMANDO: begin
                a_d          = a_q >> 1;
                b_d          = b_q >> 1;
                // New bit enters at the MSB so the LSB-first result ends aligned.
                sum_d        = sum_q >> 1;
                sum_d[ANCHO-1] = s_bit;
                c_d          = c_sig;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == ULTIMO) begin
                    valido_d = 1'b1;
                    estado_d = ST_HECHO;
                end
            end
            ST_HECHO: begin
                if (valido_q && i_listo) begin
                    valido_d = 1'b0;
                    listo_d  = 1'b1;
                    estado_d = ST_REPOSO;
                end
            end
            default: begin
                valido_d = 1'b0;
                listo_d  = 1'b1;
                estado_d = ST_REPOSO;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            estado_q <= ST_REPOSO;
            listo_q  <= 1'b1;
            valido_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            listo_q  <= listo_d;
            valido_q <= valido_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_listo   = listo_q;
    assign o_valido  = valido_q;
    assign o_suma    = sum_q;
    assign o_acarreo = c_q;

endmodule

// File: tb/tb_control_sumador_serie.sv
module tb_control_sumador_serie;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_valido;
    logic       o_listo;
    logic [7:0] i_operando_a;
    logic [7:0] i_operando_b;
    logic       o_valido;
    logic       i_listo;
    logic [7:0] o_suma;
    logic       o_acarreo;

    logic       v1_valido;
    logic       v1_listo_out;
    logic [0:0] v1_a;
    logic [0:0] v1_b;
    logic       v1_valido_out;
    logic       v1_listo;
    logic [0:0] v1_suma;
    logic       v1_acarreo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_sumador_serie #(.ANCHO(8)) u_dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_valido     (i_valido),
        .o_listo      (o_listo),
        .i_operando_a (i_operando_a),
        .i_operando_b (i_operando_b),
        .o_valido     (o_valido),
        .i_listo      (i_listo),
        .o_suma       (o_suma),
        .o_acarreo    (o_acarreo)
    );

    control_sumador_serie #(.ANCHO(1)) u_dut1 (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_valido     (v1_valido),
        .o_listo      (v1_listo_out),
        .i_operando_a (v1_a),
        .i_operando_b (v1_b),
        .o_valido     (v1_valido_out),
        .i_listo      (v1_listo),
        .o_suma       (v1_suma),
        .o_acarreo    (v1_acarreo)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
        int         hold;
    } vec_t;

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } vec1_t;

    vec_t  tabla[9];
    vec1_t tabla1[4];

    task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nombre, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the 8-bit instance; 'spam' keeps i_valido high
    // with different operands while the addition runs.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s,
                         input logic c, input int hold, input bit spam);
        int lat;
        i_valido     = 1'b1;
        i_operando_a = a;
        i_operando_b = b;
        chk("listo_reposo", 64'(o_listo), 64'(1'b1));
        step();
        if (spam) begin
            i_operando_a = ~a;
            i_operando_b = 8'h5A;
        end else begin
            i_valido     = 1'b0;
            i_operando_a = 8'($urandom);
            i_operando_b = 8'($urandom);
        end
        lat = 0;
        while (!o_valido && lat < 40) begin
            step();
            lat++;
        end
        i_valido = 1'b0;
        chk("latencia", 64'(lat), 64'(8));
        chk("suma", 64'(o_suma), 64'(s));
        chk("acarreo", 64'(o_acarreo), 64'(c));
        chk("listo_hecho", 64'(o_listo), 64'(1'b0));
        for (int k = 0; k < hold; k++) begin
            i_listo = 1'b0;
            step();
            chk("valido_retenido", 64'(o_valido), 64'(1'b1));
            chk("suma_retenida", 64'(o_suma), 64'(s));
            chk("acarreo_retenido", 64'(o_acarreo), 64'(c));
            chk("listo_retenido", 64'(o_listo), 64'(1'b0));
        end
        i_listo = 1'b1;
        step();
        i_listo = 1'b0;
        chk("valido_tras_entrega", 64'(o_valido), 64'(1'b0));
        chk("listo_tras_entrega", 64'(o_listo), 64'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tabla[0] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1, hold: 0};
        tabla[1] = '{a: 8'hA5, b: 8'h5A, s: 8'hFF, c: 1'b0, hold: 5};
        tabla[2] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0, hold: 0};
        tabla[3] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1, hold: 1};
        tabla[4] = '{a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0, hold: 0};
        tabla[5] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1, hold: 2};
        tabla[6] = '{a: 8'h3C, b: 8'hC3, s: 8'hFF, c: 1'b0, hold: 0};
        tabla[7] = '{a: 8'h01, b: 8'h01, s: 8'h02, c: 1'b0, hold: 0};
        tabla[8] = '{a: 8'hC8, b: 8'h64, s: 8'h2C, c: 1'b1, hold: 0};

        tabla1[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
        tabla1[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
        tabla1[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
        tabla1[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

        i_rst        = 1'b1;
        i_valido     = 1'b0;
        i_listo      = 1'b0;
        i_operando_a = '0;
        i_operando_b = '0;
        v1_valido    = 1'b0;
        v1_listo     = 1'b0;
        v1_a         = '0;
        v1_b         = '0;
        step();
        step();
        i_rst = 1'b0;

        chk("rst_listo", 64'(o_listo), 64'(1'b1));
        chk("rst_valido", 64'(o_valido), 64'(1'b0));
        chk("rst_suma", 64'(o_suma), 64'(0));
        chk("rst_acarreo", 64'(o_acarreo), 64'(1'b0));

        for (int i = 0; i < 9; i++) begin
            do_op(tabla[i].a, tabla[i].b, tabla[i].s, tabla[i].c, tabla[i].hold, 1'b0);
        end

        // Operands offered during SUMANDO must be ignored.
        do_op(8'h12, 8'h34, 8'h46, 1'b0, 0, 1'b1);

        // Reset during the third SUMANDO cycle aborts the operation.
        i_valido     = 1'b1;
        i_operando_a = 8'hFF;
        i_operando_b = 8'h01;
        step();
        i_valido = 1'b0;
        step();
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("abort_listo", 64'(o_listo), 64'(1'b1));
        chk("abort_valido", 64'(o_valido), 64'(1'b0));
        chk("abort_suma", 64'(o_suma), 64'(0));
        chk("abort_acarreo", 64'(o_acarreo), 64'(1'b0));
        do_op(8'h10, 8'h20, 8'h30, 1'b0, 0, 1'b0);

        // Single-bit build: one SUMANDO cycle per operation.
        for (int i = 0; i < 4; i++) begin
            int lat;
            v1_valido = 1'b1;
            v1_a      = tabla1[i].a;
            v1_b      = tabla1[i].b;
            chk("a1_listo", 64'(v1_listo_out), 64'(1'b1));
            step();
            v1_valido = 1'b0;
            lat = 0;
            while (!v1_valido_out && lat < 10) begin
                step();
                lat++;
            end
            chk("a1_latencia", 64'(lat), 64'(1));
            chk("a1_resultado", 64'({v1_acarreo, v1_suma}), 64'({tabla1[i].c, tabla1[i].s}));
            v1_listo = 1'b1;
            step();
            v1_listo = 1'b0;
            chk("a1_listo_tras", 64'(v1_listo_out), 64'(1'b1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
